qtr_rc_reader: RTL and testbench

- Drives the 8-channel RC reflectance sensor array and produces the 8-bit binary line pattern consumed by the motor direction logic.
- Each scan: enable IR emitters, charge the sensor capacitors, release the lines, and time each line's discharge.
- A channel reads 1 (line/dark) when its discharge time is at least THRESH_CYCLES.
- Sits between the sensor I/O pads (tristate split into oe/out/in) and the direction controller.

---
 rtl/qtr_rc_reader.sv | 144 ++++++++++++++
 tb/tb_qtr_rc_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/qtr_rc_reader.sv
// RC reflectance array reader: charge, release and time each line's discharge.
// clk/reset/enable in; sensor_in/oe/out pads; emitter_on, direction_command, sample_valid, busy out.
module qtr_rc_reader #(
  parameter int N_SENS            = 8,
  parameter int LED_SETTLE_CYCLES = 2500,
  parameter int CHARGE_CYCLES     = 500,
  parameter int THRESH_CYCLES     = 50000,
  parameter int TIMEOUT_CYCLES    = 150000,
  parameter int CNT_W             = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_SENS-1:0] sensor_in,
  output logic [N_SENS-1:0] sensor_oe,
  output logic [N_SENS-1:0] sensor_out,
  output logic              emitter_on,
  output logic [N_SENS-1:0] direction_command,
  output logic              sample_valid,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHARGE,
    MEASURE,
    LATCH
  } state_t;

  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(LED_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHARGE_LAST = CNT_W'(CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_VAL      = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TH_VAL      = CNT_W'(THRESH_CYCLES);

  state_t            state;
  logic [N_SENS-1:0] sync1;
  logic [N_SENS-1:0] sync2;
  logic [N_SENS-1:0] done;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  t     [N_SENS];
  logic [CNT_W-1:0]  t_nxt [N_SENS];
  logic [N_SENS-1:0] hit;
  logic [N_SENS-1:0] done_nxt;
  logic [N_SENS-1:0] dark_nxt;
  logic              meas_exit;

  // Capture times as they will stand after this MEASURE cycle, so the
  // pattern can be latched together with the valid pulse.
  always_comb begin
    hit       = ~sync2 & ~done;
    done_nxt  = done | hit;
    meas_exit = (&done_nxt) || (cnt == TO_LAST);
    dark_nxt  = '0;
    for (int i = 0; i < N_SENS; i++) begin
      t_nxt[i] = t[i];
      if (hit[i])
        t_nxt[i] = cnt;
      else if (meas_exit && !done[i])
        t_nxt[i] = TO_VAL;
      dark_nxt[i] = (t_nxt[i] >= TH_VAL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      sync1             <= '0;
      sync2             <= '0;
      done              <= '0;
      cnt               <= '0;
      sensor_oe         <= '0;
      sensor_out        <= '0;
      emitter_on        <= 1'b0;
      direction_command <= '0;
      sample_valid      <= 1'b0;
      busy              <= 1'b0;
      for (int i = 0; i < N_SENS; i++)
        t[i] <= '0;
    end else begin
      sync1        <= sensor_in;
      sync2        <= sync1;
      sample_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state      <= SETTLE;
            emitter_on <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state      <= CHARGE;
            cnt        <= '0;
            sensor_oe  <= '1;
            sensor_out <= '1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        CHARGE: begin
          if (cnt == CHARGE_LAST) begin
            state      <= MEASURE;
            cnt        <= '0;
            sensor_oe  <= '0;
            sensor_out <= '0;
            done       <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        MEASURE: begin
          done <= done_nxt;
          for (int i = 0; i < N_SENS; i++)
            t[i] <= t_nxt[i];
          if (meas_exit) begin
            state             <= LATCH;
            emitter_on        <= 1'b0;
            direction_command <= dark_nxt;
            sample_valid      <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        LATCH: begin
          cnt <= '0;
          if (enable) begin
            state      <= SETTLE;
            emitter_on <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qtr_rc_reader.sv
// Bench for qtr_rc_reader: RC pad model plus a scan-level reference model.
// Directed scenarios followed by randomized back-to-back scans.
module tb_qtr_rc_reader;

  localparam int NS      = 8;
  localparam int SETTLE  = 4;
  localparam int CHARGE  = 8;
  localparam int THRESH  = 20;
  localparam int TIMEOUT = 40;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [NS-1:0] sensor_in;
  logic [NS-1:0] sensor_oe;
  logic [NS-1:0] sensor_out;
  logic          emitter_on;
  logic [NS-1:0] direction_command;
  logic          sample_valid;
  logic          busy;

  int checks = 0;
  int fails  = 0;
  int kk [NS];
  bit in_scan = 0;
  logic [NS-1:0] last_dc;

  qtr_rc_reader #(
    .N_SENS(NS),
    .LED_SETTLE_CYCLES(SETTLE),
    .CHARGE_CYCLES(CHARGE),
    .THRESH_CYCLES(THRESH),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W(18)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sensor_in(sensor_in),
    .sensor_oe(sensor_oe),
    .sensor_out(sensor_out),
    .emitter_on(emitter_on),
    .direction_command(direction_command),
    .sample_valid(sample_valid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad model: r is the measure-cycle index (negative during charge).
  // Raw low from cycle k-2 makes the synchronised value low at cnt=k.
  initial begin
    int r;
    bit prev_oe;
    r = 1000;
    prev_oe = 0;
    sensor_in = '1;
    forever begin
      @(negedge clk);
      if (sensor_oe == '1) begin
        if (!prev_oe) r = -CHARGE;
        else r++;
      end else begin
        r++;
      end
      prev_oe = (sensor_oe == '1);
      for (int i = 0; i < NS; i++)
        sensor_in[i] = (r >= kk[i] - 2) ? 1'b0 : 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pattern(input logic [NS-1:0] p);
    for (int i = 0; i < NS; i++)
      kk[i] = p[i] ? 25 : 3;
  endtask

  task automatic set_random();
    for (int i = 0; i < NS; i++)
      kk[i] = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 45));
  endtask

  // Runs one scan to its valid pulse and checks it against the model,
  // then checks the cycle after LATCH.
  task automatic run_scan(input string tag, input bit drop_en,
                          input bit chk_settle);
    int len, settle, guard, mx, m, exp_len, tv;
    bit prev_em, seen_charge, got, allfast, exp_en;
    logic [NS-1:0] exp_dc, obs_dc;
    mx = 0;
    allfast = 1;
    exp_dc = '0;
    for (int i = 0; i < NS; i++) begin
      if (kk[i] >= TIMEOUT) allfast = 0;
      else if (kk[i] > mx) mx = kk[i];
      tv = (kk[i] < TIMEOUT) ? kk[i] : TIMEOUT;
      exp_dc[i] = (tv >= THRESH);
    end
    m = allfast ? mx + 1 : TIMEOUT;
    exp_len = SETTLE + CHARGE + m + 1;
    len = in_scan ? 1 : 0;
    settle = in_scan ? 1 : 0;
    seen_charge = 0;
    got = 0;
    guard = 0;
    obs_dc = '0;
    prev_em = emitter_on;
    while (!got && guard < 500) begin
      @(negedge clk);
      guard++;
      if (emitter_on && !prev_em) len = 1;
      else if (len > 0) len++;
      if (len > 0 && !seen_charge) begin
        if (sensor_oe != '0) seen_charge = 1;
        else settle++;
      end
      if (drop_en && seen_charge && len > SETTLE + CHARGE + 2)
        enable = 1'b0;
      if (sample_valid) begin
        got = 1;
        obs_dc = direction_command;
      end
      prev_em = emitter_on;
    end
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_dc"}, 32'(obs_dc), 32'(exp_dc));
    check({tag, "_len"}, 32'(len), 32'(exp_len));
    if (chk_settle)
      check({tag, "_settle"}, 32'(settle), 32'(SETTLE));
    last_dc = exp_dc;
    exp_en = enable;
    @(negedge clk);
    check({tag, "_pulse1"}, 32'(sample_valid), 32'd0);
    check({tag, "_em_after"}, 32'(emitter_on), 32'(exp_en));
    check({tag, "_busy_after"}, 32'(busy), 32'(exp_en));
    in_scan = exp_en;
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < NS; i++) kk[i] = 1000;
    repeat (3) @(negedge clk);
    check("rst_oe", 32'(sensor_oe), 32'd0);
    check("rst_out", 32'(sensor_out), 32'd0);
    check("rst_em", 32'(emitter_on), 32'd0);
    check("rst_dc", 32'(direction_command), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Two slow channels set the measure length.
    for (int i = 0; i < NS; i++) kk[i] = 5;
    kk[4] = 30;
    kk[3] = 30;
    enable = 1'b1;
    run_scan("slow43", 0, 1);

    // Reset in the middle of the next charge phase.
    guard = 0;
    while (sensor_oe != '1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("charge_seen", 32'(sensor_oe), 32'hFF);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_oe", 32'(sensor_oe), 32'd0);
    check("midrst_em", 32'(emitter_on), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_dc", 32'(direction_command), 32'd0);
    check("midrst_valid", 32'(sample_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    in_scan = 0;
    set_random();
    run_scan("after_rst", 0, 1);

    for (int i = 0; i < NS; i++) kk[i] = 1000;
    run_scan("timeout", 0, 1);
    for (int i = 0; i < NS; i++) kk[i] = 2;
    run_scan("all_fast", 0, 1);

    for (int i = 0; i < NS; i++) kk[i] = 1;
    kk[7] = 19;
    kk[0] = 20;
    run_scan("thresh", 0, 1);

    for (int i = 0; i < NS; i++) kk[i] = 0;
    run_scan("low_at0", 0, 1);

    set_pattern(8'h18);
    run_scan("b2b_18", 0, 1);
    set_pattern(8'h80);
    run_scan("b2b_80", 0, 1);
    set_pattern(8'h03);
    run_scan("b2b_03", 0, 1);

    // Enable drops mid-measure; the scan still completes once.
    set_random();
    kk[0] = 35;
    run_scan("drop_en", 1, 1);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check("idle_dc", 32'(direction_command), 32'(last_dc));
      check("idle_valid", 32'(sample_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_em", 32'(emitter_on), 32'd0);
    end

    enable = 1'b1;
    for (int s = 0; s < 20; s++) begin
      set_random();
      if (s == 19) run_scan("rand_last", 1, 1);
      else run_scan("rand", 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
